// File: rtl/iob_ptfloat_unpack_if.sv
// ---------------------------------------------------------------------------
// IobPtfloatUnpackIf
//
// Purpose:
//    Bundles the word-in / decoded-value-out signals of the pt-float unpacker
//    so that producer, unpacker and consumer agree on widths derived from a
//    single pair of parameters.
//
// Parameters:
//    DATA_W  packed pt-float word width
//    EW_W    width of the leading exponent-width field
//
// Signals (direction as seen from the unpacker, i.e. the slave modport):
//    start_i  in   1          data_i carries a word this cycle
//    data_i   in   DATA_W     packed pt-float word
//    done_o   out  1          one-cycle pulse, exp_o/man_o/nar_o are new
//    exp_o    out  EXP_MAX_W  signed unbiased exponent
//    man_o    out  MAN_MAX_W  two's-complement mantissa, MSB aligned
//    nar_o    out  1          Not-a-Real flag
//
// Modports:
//    master  the side that feeds words in and consumes decoded results
//    slave   the unpacker itself
// ---------------------------------------------------------------------------
interface iob_ptfloat_unpack_if #(
   parameter int DATA_W = 32,
   parameter int EW_W   = 4
);

   localparam int EXP_MAX_W = 2**EW_W - 1;
   localparam int MAN_MAX_W = DATA_W - EW_W;

   logic                 start_i;
   logic [DATA_W-1:0]    data_i;
   logic                 done_o;
   logic [EXP_MAX_W-1:0] exp_o;
   logic [MAN_MAX_W-1:0] man_o;
   logic                 nar_o;

   modport master (
      output start_i,
      output data_i,
      input  done_o,
      input  exp_o,
      input  man_o,
      input  nar_o
   );

   modport slave (
      input  start_i,
      input  data_i,
      output done_o,
      output exp_o,
      output man_o,
      output nar_o
   );

endinterface

// File: rtl/iob_ptfloat_unpack.sv
// ---------------------------------------------------------------------------
// iob_ptfloat_unpack
//
// Purpose:
//    Two-stage pipelined decoder that splits a packed pt-float word into a
//    sign-extended exponent and an MSB-aligned two's-complement mantissa,
//    in the exponent/mantissa form expected by the ptfloat-to-IEEE stage.
//
//    Packed word layout, MSB first:
//       [EW_W bits]  ew   - width of the exponent field (clamped so at least
//                           one mantissa bit remains)
//       [ew bits]    signed exponent (absent when ew == 0 -> exponent 0)
//       [rest]       mantissa, left-justified into MAN_MAX_W bits on output
//    A decoded mantissa of zero is reported as exp = EXP_MIN, man = 0.
//
// Parameters:
//    DATA_W  packed word width            (default 32)
//    EW_W    exponent-width field width   (default 4)
//
// Ports:
//    clk_i   in  clock, all state updates on the rising edge
//    arst_i  in  asynchronous reset, active low
//    cke_i   in  clock enable, low freezes every register (done included)
//    bus     slave modport of iob_ptfloat_unpack_if:
//               start_i/data_i in, done_o/exp_o/man_o/nar_o out
//
// Configuration macro:
//    IOB_PTFLOAT_UNPACK_NAR_EN
//       defined   : the word 1000...0 raises nar_o together with done_o and
//                   decodes as exp = EXP_MIN, man = 0
//       undefined : nar_o is tied to 0 and that word simply decodes as zero
//
// Latency is two enabled clock edges from start_i sampled to done_o high,
// with one word accepted per enabled cycle.
// ---------------------------------------------------------------------------
module iob_ptfloat_unpack #(
   parameter int DATA_W = 32,
   parameter int EW_W   = 4
) (
   input  logic                   clk_i,
   input  logic                   arst_i,
   input  logic                   cke_i,
   iob_ptfloat_unpack_if.slave    bus
);

   localparam int EXP_MAX_W = 2**EW_W - 1;
   localparam int MAN_MAX_W = DATA_W - EW_W;
   // Largest exponent width that still leaves one mantissa bit.
   localparam int EW_MAX    = MAN_MAX_W - 1;
   // Working width for the sign-extending exponent extraction: the body is
   // placed on top of EXP_MAX_W zero bits so that an arithmetic right shift
   // leaves the exponent field, already sign extended, in the low bits.
   localparam int WIDE_W    = EXP_MAX_W + MAN_MAX_W;

   localparam logic [EXP_MAX_W-1:0] EXP_MIN = {1'b1, {(EXP_MAX_W-1){1'b0}}};

   // Stage 1 registers
   logic                  r_valid;
   logic [DATA_W-1:0]     r_data;

   // Stage 2 (output) registers
   logic                  r_done;
   logic [EXP_MAX_W-1:0]  r_exp;
   logic [MAN_MAX_W-1:0]  r_man;

   // Decode wires
   logic [EW_W-1:0]       w_ewRaw;
   int                    w_ew;
   logic [MAN_MAX_W-1:0]  w_body;
   logic signed [WIDE_W-1:0] w_expWide;
   logic [EXP_MAX_W-1:0]  w_expDec;
   logic [MAN_MAX_W-1:0]  w_manDec;
   logic [EXP_MAX_W-1:0]  w_expNext;
   logic [MAN_MAX_W-1:0]  w_manNext;
   logic                  w_isNar;

   // Stage 1: capture the incoming word. The data register only loads on an
   // accepted word so it keeps the last word while the pipe is idle; the
   // valid bit follows start_i on every enabled edge.
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (cke_i) begin
         r_valid <= bus.start_i;
         if (bus.start_i) begin
            r_data <= bus.data_i;
         end
      end
   end

   assign w_ewRaw = r_data[DATA_W-1 -: EW_W];
   assign w_body  = r_data[MAN_MAX_W-1:0];

   // Field split of the captured word. The exponent width is clamped first;
   // every later step uses the clamped value so exponent and mantissa never
   // overlap. Shifting the body left by ew both drops the exponent bits off
   // the top and zero-fills the mantissa LSBs.
   always_comb begin
      w_ew = int'(w_ewRaw);
      if (w_ew > EW_MAX) begin
         w_ew = EW_MAX;
      end

      w_expWide = $signed({w_body, {EXP_MAX_W{1'b0}}});

      if (w_ew == 0) begin
         w_expDec = '0;
      end else begin
         w_expDec = EXP_MAX_W'(w_expWide >>> (WIDE_W - w_ew));
      end

      w_manDec = w_body << w_ew;
   end

`ifdef IOB_PTFLOAT_UNPACK_NAR_EN
   localparam logic [DATA_W-1:0] NAR_WORD = {1'b1, {(DATA_W-1){1'b0}}};

   logic r_nar;

   assign w_isNar = (r_data == NAR_WORD);
`else
   assign w_isNar = 1'b0;
`endif

   // Zero and NaR both leave the exponent meaningless, so they are folded
   // onto the canonical zero encoding the downstream stage expects.
   always_comb begin
      w_expNext = w_expDec;
      w_manNext = w_manDec;
      if (w_isNar || (w_manDec == '0)) begin
         w_expNext = EXP_MIN;
         w_manNext = '0;
      end
   end

   // Stage 2: register the decoded result. done follows the stage-1 valid
   // bit; the value registers only load when a word is actually leaving the
   // pipe, so they hold their previous contents between pulses.
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         r_done <= 1'b0;
         r_exp  <= EXP_MIN;
         r_man  <= '0;
`ifdef IOB_PTFLOAT_UNPACK_NAR_EN
         r_nar  <= 1'b0;
`endif
      end else if (cke_i) begin
         r_done <= r_valid;
         if (r_valid) begin
            r_exp <= w_expNext;
            r_man <= w_manNext;
`ifdef IOB_PTFLOAT_UNPACK_NAR_EN
            r_nar <= w_isNar;
`endif
         end
      end
   end

   assign bus.done_o = r_done;
   assign bus.exp_o  = r_exp;
   assign bus.man_o  = r_man;
`ifdef IOB_PTFLOAT_UNPACK_NAR_EN
   assign bus.nar_o  = r_nar;
`else
   assign bus.nar_o  = 1'b0;
`endif

endmodule

// File: tb/tb_iob_ptfloat_unpack.sv
// ---------------------------------------------------------------------------
// tb_iob_ptfloat_unpack
//
// Self-checking bench for iob_ptfloat_unpack (DATA_W=32, EW_W=4).
// A behavioural decoder plus a queue of accepted words predicts the outputs
// after every clock edge; a compare process checks them each cycle. Directed
// sequences with literal expectations pin both the model and the DUT, and a
// randomized phase exercises cke_i, back-to-back starts and resets.
// ---------------------------------------------------------------------------
module tb_iob_ptfloat_unpack;

   localparam int DATA_W    = 32;
   localparam int EW_W      = 4;
   localparam int EXP_MAX_W = 2**EW_W - 1;
   localparam int MAN_MAX_W = DATA_W - EW_W;

`ifdef IOB_PTFLOAT_UNPACK_NAR_EN
   localparam longint NAR_EXPECT = 1;
`else
   localparam longint NAR_EXPECT = 0;
`endif

   typedef struct {
      logic [DATA_W-1:0] word;
      longint            idx;
   } acc_t;

   logic clk_i  = 1'b0;
   logic arst_i = 1'b0;
   logic cke_i  = 1'b0;

   int total = 0;
   int bad   = 0;

   iob_ptfloat_unpack_if #(.DATA_W(DATA_W), .EW_W(EW_W)) bus ();

   iob_ptfloat_unpack #(.DATA_W(DATA_W), .EW_W(EW_W)) dut (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .cke_i  (cke_i),
      .bus    (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   function automatic longint pow2(input longint k);
      return longint'(1) << k;
   endfunction

   function automatic void checkVal(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Reference decoder written with plain integer arithmetic.
   function automatic void decodeModel(input logic [DATA_W-1:0] w, output longint e,
                                       output longint m, output longint n);
      longint ew, rest, nb;
      ew = longint'(w) / pow2(MAN_MAX_W);
      if (ew > MAN_MAX_W - 1) ew = MAN_MAX_W - 1;
      rest = longint'(w) % pow2(MAN_MAX_W);
      nb   = MAN_MAX_W - ew;
      if (ew == 0) begin
         e = 0;
      end else begin
         e = rest / pow2(nb);
         if (e >= pow2(ew - 1)) e = e - pow2(ew);
      end
      m = (rest % pow2(nb)) * pow2(ew);
      n = 0;
      if (m == 0) e = -pow2(EXP_MAX_W - 1);
`ifdef IOB_PTFLOAT_UNPACK_NAR_EN
      if (longint'(w) == pow2(DATA_W - 1)) begin
         n = 1;
         e = -pow2(EXP_MAX_W - 1);
         m = 0;
      end
`endif
   endfunction

   // Scoreboard state
   acc_t   accQ[$];
   longint enCount = 0;
   longint mDone   = 0;
   longint mExp    = -16384;
   longint mMan    = 0;
   longint mNar    = 0;

   // Advance the model on each rising edge, then compare shortly after it.
   always @(posedge clk_i) begin
      acc_t   a;
      longint e, m, n;
      if (!arst_i) begin
         accQ.delete();
         mDone = 0;
         mExp  = -pow2(EXP_MAX_W - 1);
         mMan  = 0;
         mNar  = 0;
      end else if (cke_i) begin
         enCount++;
         mDone = 0;
         if (accQ.size() > 0 && accQ[0].idx == enCount - 1) begin
            a = accQ.pop_front();
            decodeModel(a.word, e, m, n);
            mDone = 1;
            mExp  = e;
            mMan  = m;
            mNar  = n;
         end
         if (bus.start_i) begin
            a.word = bus.data_i;
            a.idx  = enCount;
            accQ.push_back(a);
         end
      end
      #1;
      checkVal("sb_done", longint'(bus.done_o), mDone);
      checkVal("sb_exp",  longint'($signed(bus.exp_o)), mExp);
      checkVal("sb_man",  longint'(bus.man_o), mMan);
      checkVal("sb_nar",  longint'(bus.nar_o), mNar);
   end

   // One-cycle start pulse, returns right after it was sampled.
   task automatic applyStimulus(input logic [DATA_W-1:0] w);
      @(negedge clk_i);
      bus.start_i = 1'b1;
      bus.data_i  = w;
      @(negedge clk_i);
      bus.start_i = 1'b0;
   endtask

   task automatic checkOutput(input string name, input longint d, input longint e,
                              input longint m, input longint n);
      checkVal({name, "_done"}, longint'(bus.done_o), d);
      checkVal({name, "_exp"},  longint'(bus.exp_o), e);
      checkVal({name, "_man"},  longint'(bus.man_o), m);
      checkVal({name, "_nar"},  longint'(bus.nar_o), n);
   endtask

   function automatic logic [DATA_W-1:0] randWord();
      logic [DATA_W-1:0] w;
      w = DATA_W'($urandom);
      case ($urandom_range(0, 9))
         0: w = '0;
         1: w = {1'b1, {(DATA_W-1){1'b0}}};
         2: w = {w[DATA_W-1 -: EW_W], {MAN_MAX_W{1'b0}}};
         3: w[DATA_W-1 -: EW_W] = '1;
         default: ;
      endcase
      return w;
   endfunction

   int                seqStart[10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
   int                seqCke[10]   = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
   logic [DATA_W-1:0] seqData[3]   = '{32'h04000000, 32'h3F000000, 32'hF0008001};
   longint            seenMan[$];

   initial begin
      longint e, m, n;
      bus.start_i = 1'b0;
      bus.data_i  = '0;

      // Model pinned to hand-computed values.
      decodeModel(32'h04000000, e, m, n);
      checkVal("model_033_exp", e, 0);
      checkVal("model_033_man", m, 64'h4000000);
      decodeModel(32'h3F000000, e, m, n);
      checkVal("model_034_exp", e, -1);
      checkVal("model_034_man", m, 64'h8000000);
      decodeModel(32'h00000000, e, m, n);
      checkVal("model_035_exp", e, -16384);
      decodeModel(32'h80000000, e, m, n);
      checkVal("model_036_nar", n, NAR_EXPECT);
      checkVal("model_036_man", m, 0);

      // Reset state.
      repeat (2) @(negedge clk_i);
      arst_i = 1'b1;
      cke_i  = 1'b1;
      @(negedge clk_i);
      checkOutput("reset", 0, 64'h4000, 0, 0);

      applyStimulus(32'h04000000);
      @(negedge clk_i);
      checkOutput("d033", 1, 64'h0000, 64'h4000000, 0);
      @(negedge clk_i);
      checkOutput("d033_hold", 0, 64'h0000, 64'h4000000, 0);

      applyStimulus(32'h3F000000);
      @(negedge clk_i);
      checkOutput("d034", 1, 64'h7FFF, 64'h8000000, 0);

      applyStimulus(32'h00000000);
      @(negedge clk_i);
      checkOutput("d035", 1, 64'h4000, 0, 0);

      applyStimulus(32'h80000000);
      @(negedge clk_i);
      checkOutput("d036", 1, 64'h4000, 0, NAR_EXPECT);

      applyStimulus(32'hF0008001);
      @(negedge clk_i);
      checkOutput("d_ew15", 1, 64'h0004, 64'h8000, 0);

      // Back-to-back words with a two-cycle clock-enable stall.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (cke_i && bus.done_o) seenMan.push_back(longint'(bus.man_o));
         bus.start_i = seqStart[i][0];
         bus.data_i  = (i < 3) ? seqData[i] : '0;
         cke_i       = seqCke[i][0];
      end
      checkVal("d037_count", longint'(seenMan.size()), 3);
      if (seenMan.size() == 3) begin
         checkVal("d037_first",  seenMan[0], 64'h4000000);
         checkVal("d037_second", seenMan[1], 64'h8000000);
         checkVal("d037_third",  seenMan[2], 64'h8000);
      end

      // Reset one cycle after a start discards the word.
      applyStimulus(32'h3F000000);
      arst_i = 1'b0;
      @(negedge clk_i);
      arst_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         checkOutput("d038", 0, 64'h4000, 0, 0);
      end

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_i);
         if (!arst_i) arst_i = 1'b1;
         else if ($urandom_range(0, 399) == 0) arst_i = 1'b0;
         cke_i       = ($urandom_range(0, 9) != 0);
         bus.start_i = ($urandom_range(0, 2) != 0);
         bus.data_i  = randWord();
      end

      @(negedge clk_i);
      arst_i      = 1'b1;
      cke_i       = 1'b1;
      bus.start_i = 1'b0;
      repeat (5) @(negedge clk_i);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
